multi_port_ram: RTL and testbench

MULTI_PORT_RAM -- requirements
Module: multi_port_ram

---
 rtl/multi_port_ram_pkg.sv | 14 +
 rtl/multi_port_ram_if.sv | 33 +++
 rtl/multi_port_ram_rr_arbiter.sv | 40 ++++
 rtl/multi_port_ram.sv | 174 +++++++++++++++++
 tb/tb_multi_port_ram.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_port_ram_pkg.sv
// Shared types and helpers for the multi-requester RAM.
package multi_port_ram_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } ram_state_e;

   // Width of a channel index; never narrower than one bit.
   function automatic int unsigned ch_idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/multi_port_ram_if.sv
// Request/response bundle between the requesters (master) and multi_port_ram (slave).
interface multi_port_ram_if #(
   parameter int unsigned CHANNELS   = 4,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 32
);
   import multi_port_ram_pkg::*;

   localparam int unsigned CH_W = ch_idx_w(CHANNELS);
   localparam int unsigned BE_W = DATA_WIDTH / 8;

   logic [CHANNELS-1:0]            req;
   logic [CHANNELS-1:0]            we;
   logic [CHANNELS*ADDR_WIDTH-1:0] addr;
   logic [CHANNELS*DATA_WIDTH-1:0] data_in;
   logic [CHANNELS*BE_W-1:0]       be;
   logic [CHANNELS-1:0]            ready;
   logic [DATA_WIDTH-1:0]          data_out;
   logic                           data_out_valid;
   logic [CH_W-1:0]                data_out_ch;
   logic                           busy;

   modport master (
      output req, we, addr, data_in, be,
      input  ready, data_out, data_out_valid, data_out_ch, busy
   );

   modport slave (
      input  req, we, addr, data_in, be,
      output ready, data_out, data_out_valid, data_out_ch, busy
   );

endinterface

// File: rtl/multi_port_ram_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr (wrapping) wins.
module rr_arbiter
   import multi_port_ram_pkg::*;
#(
   parameter int unsigned CHANNELS = 4
) (
   input  logic [CHANNELS-1:0]           req,
   input  logic [ch_idx_w(CHANNELS)-1:0] ptr,
   output logic [CHANNELS-1:0]           grant,
   output logic [ch_idx_w(CHANNELS)-1:0] grant_idx,
   output logic                          grant_vld
);
   localparam int unsigned CH_W = ch_idx_w(CHANNELS);
   localparam int unsigned IW   = CH_W + 1;

   logic [CHANNELS-1:0] rot_c;
   logic [IW-1:0]       pos_c;

   // Rotate so bit 0 is the pointer position, pick lowest set bit, rotate back.
   always_comb begin
      rot_c     = CHANNELS'({req, req} >> ptr);
      grant_vld = 1'b0;
      grant     = '0;
      pos_c     = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (!grant_vld && rot_c[k]) begin
            grant_vld = 1'b1;
            pos_c     = IW'(ptr) + IW'(k);
         end
      end
      if (pos_c >= IW'(CHANNELS)) begin
         pos_c = pos_c - IW'(CHANNELS);
      end
      grant_idx = CH_W'(pos_c);
      if (grant_vld) begin
         grant[grant_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/multi_port_ram.sv
// Shared single-port RAM for CHANNELS requesters: round-robin grant, byte-enable writes,
// two-cycle read pipeline. Define MULTI_PORT_RAM_CLEAR_EN to zero-fill the array after reset.
module multi_port_ram
   import multi_port_ram_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned CHANNELS   = 4,
   parameter string       RAM_TYPE   = "auto"
) (
   input logic             clk,
   input logic             reset,
   multi_port_ram_if.slave bus
);
   localparam int unsigned CH_W  = ch_idx_w(CHANNELS);
   localparam int unsigned BE_W  = DATA_WIDTH / 8;
   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   logic                  busy_w;
   logic [CH_W-1:0]       ptr_q;
   logic [CHANNELS-1:0]   req_c;
   logic [CHANNELS-1:0]   grant_c;
   logic [CH_W-1:0]       grant_idx_c;
   logic                  grant_vld_c;

   logic [ADDR_WIDTH-1:0] sel_addr_c;
   logic [DATA_WIDTH-1:0] sel_data_c;
   logic [BE_W-1:0]       sel_be_c;
   logic                  sel_we_c;

   logic                  wr_en_c;
   logic [ADDR_WIDTH-1:0] wr_addr_c;
   logic [DATA_WIDTH-1:0] wr_data_c;
   logic [BE_W-1:0]       wr_be_c;

   logic                  rd_vld_q;
   logic [ADDR_WIDTH-1:0] rd_addr_q;
   logic [CH_W-1:0]       rd_ch_q;
   logic [DATA_WIDTH-1:0] rd_word_c;

   logic                  dout_vld_q;
   logic [DATA_WIDTH-1:0] dout_q;
   logic [CH_W-1:0]       dout_ch_q;

`ifdef MULTI_PORT_RAM_CLEAR_EN
   ram_state_e            state_q;
   logic [ADDR_WIDTH-1:0] clr_addr_q;
   logic                  busy_q;

   // Clear sweeps every address once, then stays in RUN until the next reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_CLEAR;
         clr_addr_q <= '0;
         busy_q     <= 1'b1;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               clr_addr_q <= clr_addr_q + ADDR_WIDTH'(1);
               if (clr_addr_q == '1) begin
                  state_q <= ST_RUN;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_RUN;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_w = busy_q;
`else
   assign busy_w = 1'b0;
`endif

   assign req_c = bus.req & {CHANNELS{~busy_w}};

   rr_arbiter #(
      .CHANNELS (CHANNELS)
   ) u_arb (
      .req       (req_c),
      .ptr       (ptr_q),
      .grant     (grant_c),
      .grant_idx (grant_idx_c),
      .grant_vld (grant_vld_c)
   );

   assign bus.ready = grant_c;
   assign bus.busy  = busy_w;

   // Payload of the granted channel.
   always_comb begin
      sel_addr_c = bus.addr[grant_idx_c*ADDR_WIDTH +: ADDR_WIDTH];
      sel_data_c = bus.data_in[grant_idx_c*DATA_WIDTH +: DATA_WIDTH];
      sel_be_c   = bus.be[grant_idx_c*BE_W +: BE_W];
      sel_we_c   = bus.we[grant_idx_c];
   end

   // Single write port, shared by the clear sweep and granted writes; reset blocks both.
   always_comb begin
      wr_en_c   = grant_vld_c & sel_we_c & ~reset;
      wr_addr_c = sel_addr_c;
      wr_data_c = sel_data_c;
      wr_be_c   = sel_be_c;
`ifdef MULTI_PORT_RAM_CLEAR_EN
      if (state_q == ST_CLEAR) begin
         wr_en_c   = ~reset;
         wr_addr_c = clr_addr_q;
         wr_data_c = '0;
         wr_be_c   = '1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= '0;
      end else if (grant_vld_c) begin
         ptr_q <= (grant_idx_c == CH_W'(CHANNELS - 1)) ? '0 : grant_idx_c + CH_W'(1);
      end
   end

   if (RAM_TYPE == "distributed") begin : g_dist
      (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
      always_ff @(posedge clk) begin
         if (wr_en_c) begin
            for (int b = 0; b < BE_W; b++) begin
               if (wr_be_c[b]) mem[wr_addr_c][b*8 +: 8] <= wr_data_c[b*8 +: 8];
            end
         end
      end
      assign rd_word_c = mem[rd_addr_q];
   end else begin : g_auto
      logic [DATA_WIDTH-1:0] mem [DEPTH];
      always_ff @(posedge clk) begin
         if (wr_en_c) begin
            for (int b = 0; b < BE_W; b++) begin
               if (wr_be_c[b]) mem[wr_addr_c][b*8 +: 8] <= wr_data_c[b*8 +: 8];
            end
         end
      end
      assign rd_word_c = mem[rd_addr_q];
   end

   // Read pipeline: address registered at grant, data registered one cycle later.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_vld_q   <= 1'b0;
         rd_addr_q  <= '0;
         rd_ch_q    <= '0;
         dout_vld_q <= 1'b0;
         dout_q     <= '0;
         dout_ch_q  <= '0;
      end else begin
         rd_vld_q   <= grant_vld_c & ~sel_we_c;
         if (grant_vld_c && !sel_we_c) begin
            rd_addr_q <= sel_addr_c;
            rd_ch_q   <= grant_idx_c;
         end
         dout_vld_q <= rd_vld_q;
         if (rd_vld_q) begin
            dout_q    <= rd_word_c;
            dout_ch_q <= rd_ch_q;
         end
      end
   end

   assign bus.data_out       = dout_q;
   assign bus.data_out_valid = dout_vld_q;
   assign bus.data_out_ch    = dout_ch_q;

endmodule

// File: tb/tb_multi_port_ram.sv
// Bench for multi_port_ram: directed scenarios plus held random requests against a word-level model.
// Compile with MULTI_PORT_RAM_CLEAR_EN to also exercise the clear sweep.
module tb_multi_port_ram;
   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 10;
   localparam int unsigned CH    = 4;
   localparam int unsigned BW    = DW / 8;
   localparam int unsigned CW    = 2;
   localparam int unsigned DEPTH = 1 << AW;
`ifdef MULTI_PORT_RAM_CLEAR_EN
   localparam int          CLR_CYC = DEPTH;
`else
   localparam int          CLR_CYC = 0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   multi_port_ram_if #(.CHANNELS(CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   multi_port_ram #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .CHANNELS   (CH),
      .RAM_TYPE   ("auto")
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Requester intent
   bit             r_req  [CH];
   bit             r_we   [CH];
   logic [AW-1:0]  r_addr [CH];
   logic [DW-1:0]  r_data [CH];
   logic [BW-1:0]  r_be   [CH];

   // Reference model
   logic [DW-1:0]  m_mem   [DEPTH];
   bit             m_known [DEPTH];
   int             m_p;
   int             clr_left;
   bit             s1_v, s1_k;
   int             s1_ch;
   logic [DW-1:0]  s1_d;
   bit             out_v, out_k;
   int             out_ch;
   logic [DW-1:0]  out_d;
   int             last_grant;

   // DUT observations of the most recent step
   logic [CH-1:0]  obs_ready;
   logic           obs_v;
   logic [CW-1:0]  obs_ch;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr_reqs();
      for (int i = 0; i < CH; i++) begin
         r_req[i] = 1'b0; r_we[i] = 1'b0; r_addr[i] = '0; r_data[i] = '0; r_be[i] = '0;
      end
   endtask

   task automatic drive();
      for (int i = 0; i < CH; i++) begin
         bus.req[i]                = r_req[i];
         bus.we[i]                 = r_we[i];
         bus.addr[i*AW +: AW]      = r_addr[i];
         bus.data_in[i*DW +: DW]   = r_data[i];
         bus.be[i*BW +: BW]        = r_be[i];
      end
   endtask

   function automatic void mdl_reset();
      m_p = 0; s1_v = 0; s1_k = 0; s1_ch = 0; s1_d = '0;
      out_v = 0; out_k = 1; out_ch = 0; out_d = '0;
      clr_left = CLR_CYC;
   endfunction

   // One clock cycle: drive, compare against the model, then advance the model across the edge.
   task automatic step(input bit rst);
      int g;
      int c;
      logic [CH-1:0] exp_ready;
      reset = rst;
      drive();
      #1;
      g = -1;
      if (clr_left == 0) begin
         for (int k = 0; k < CH; k++) begin
            c = (m_p + k) % CH;
            if (g < 0 && r_req[c]) g = c;
         end
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      obs_ready = bus.ready;
      obs_v     = bus.data_out_valid;
      obs_ch    = bus.data_out_ch;
      check("ready", 64'(obs_ready), 64'(exp_ready));
      check("busy", 64'(bus.busy), 64'(clr_left > 0));
      check("data_out_valid", 64'(obs_v), 64'(out_v));
      check("data_out_ch", 64'(obs_ch), 64'(out_ch));
      if (out_k) check("data_out", 64'(bus.data_out), 64'(out_d));

      if (rst) begin
         mdl_reset();
      end else begin
         out_v = s1_v;
         if (s1_v) begin out_d = s1_d; out_ch = s1_ch; out_k = s1_k; end
         s1_v = (g >= 0) && !r_we[g];
         if (s1_v) begin
            s1_ch = g; s1_d = m_mem[r_addr[g]]; s1_k = m_known[r_addr[g]];
         end
         if (g >= 0 && r_we[g]) begin
            for (int b = 0; b < BW; b++)
               if (r_be[g][b]) m_mem[r_addr[g]][b*8 +: 8] = r_data[g][b*8 +: 8];
            if (r_be[g] == '1) m_known[r_addr[g]] = 1'b1;
         end
         if (g >= 0) m_p = (g + 1) % CH;
         if (clr_left > 0) begin
            clr_left--;
            if (clr_left == 0)
               for (int a = 0; a < DEPTH; a++) begin m_mem[a] = '0; m_known[a] = 1'b1; end
         end
      end
      last_grant = g;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic access(input int ch, input bit we, input int a, input logic [DW-1:0] d,
                         input logic [BW-1:0] be);
      clr_reqs();
      r_req[ch] = 1'b1; r_we[ch] = we; r_addr[ch] = AW'(a); r_data[ch] = d; r_be[ch] = be;
      step(1'b0);
      clr_reqs();
   endtask

   // Bounded wait for the clear sweep; returns the number of busy cycles seen.
   task automatic wait_idle(output int n);
      n = 0;
      while (bus.busy === 1'b1 && n < 3 * DEPTH) begin
         step(1'b0);
         n++;
      end
      check("busy_timeout", 64'(bus.busy), 64'(0));
   endtask

   task automatic do_reset();
      int n;
      clr_reqs();
      step(1'b1);
      wait_idle(n);
   endtask

   initial begin
      int n;
      for (int a = 0; a < DEPTH; a++) begin m_mem[a] = '0; m_known[a] = 1'b0; end
      clr_reqs();
      reset = 1'b1;
      drive();
      repeat (3) @(posedge clk);
      @(negedge clk);
      mdl_reset();

      // Reset state
      step(1'b1);
      check("rst_data_out", 64'(bus.data_out), 64'(0));
      check("rst_valid", 64'(bus.data_out_valid), 64'(0));
      check("rst_ch", 64'(bus.data_out_ch), 64'(0));

`ifdef MULTI_PORT_RAM_CLEAR_EN
      // Clear sweep length; a held request must not be granted while busy
      n = 0;
      while (bus.busy === 1'b1 && n < 3 * DEPTH) begin
         if (n < 5) begin r_req[1] = 1'b1; r_addr[1] = '0; end else clr_reqs();
         step(1'b0);
         n++;
      end
      clr_reqs();
      check("clear_busy_cycles", 64'(n), 64'(1024));
      for (int i = 0; i < 3; i++) begin
         access(i, 1'b0, (i == 0) ? 0 : (i == 1) ? 511 : 1023, '0, '0);
         step(1'b0);
         check("clear_read_valid", 64'(bus.data_out_valid), 64'(1));
         check("clear_read_zero", 64'(bus.data_out), 64'(0));
      end
      // Reset mid-sweep restarts from address 0
      step(1'b1);
      repeat (300) step(1'b0);
      step(1'b1);
      wait_idle(n);
      check("clear_restart_cycles", 64'(n), 64'(1024));
`endif

      // Byte-enable merge and read latency
      access(0, 1'b1, 5, 32'hDEADBEEF, 4'b1111);
      access(0, 1'b1, 5, 32'h000000AA, 4'b0001);
      access(0, 1'b0, 5, '0, '0);
      check("rmw_grant", 64'(obs_ready), 64'(4'b0001));
      step(1'b0);
      check("rmw_valid", 64'(bus.data_out_valid), 64'(1));
      check("rmw_data", 64'(bus.data_out), 64'(32'hDEADBEAA));
      check("rmw_ch", 64'(bus.data_out_ch), 64'(0));
      step(1'b0);
      // be=0 write is a no-op that still takes the grant
      access(3, 1'b1, 5, 32'h12345678, 4'b0000);
      check("be0_grant", 64'(obs_ready), 64'(4'b1000));
      access(3, 1'b0, 5, '0, '0);
      step(1'b0);
      check("be0_data", 64'(bus.data_out), 64'(32'hDEADBEAA));

      // Full contention from pointer 0
      do_reset();
      for (int i = 0; i < CH; i++) begin
         r_req[i] = 1'b1; r_we[i] = 1'b0; r_addr[i] = 5;
      end
      for (int i = 0; i < 8; i++) begin
         step(1'b0);
         check("rr_grant", 64'(obs_ready), 64'(1 << (i % CH)));
         if (i >= 2) begin
            check("rr_out_valid", 64'(obs_v), 64'(1));
            check("rr_out_ch", 64'(obs_ch), 64'((i - 2) % CH));
         end
      end
      clr_reqs();
      step(1'b0);
      step(1'b0);

      // Lone requester granted every cycle, pointer then sits after it
      r_req[2] = 1'b1; r_addr[2] = 5;
      for (int i = 0; i < 3; i++) begin
         step(1'b0);
         check("solo_grant", 64'(obs_ready), 64'(4'b0100));
      end
      for (int i = 0; i < CH; i++) begin r_req[i] = 1'b1; r_addr[i] = 5; end
      step(1'b0);
      check("ptr_after_solo", 64'(obs_ready), 64'(4'b1000));
      clr_reqs();
      step(1'b0);
      step(1'b0);

      // Reset right after a read grant discards the in-flight read
      access(1, 1'b0, 5, '0, '0);
      step(1'b1);
      for (int i = 0; i < 3; i++) begin
         check("flush_valid", 64'(bus.data_out_valid), 64'(0));
         step(1'b0);
      end
      wait_idle(n);

      // Initialise a small window, then random held requests
      for (int a = 0; a < 32; a++) access(a % CH, 1'b1, a, DW'($urandom), 4'b1111);
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int i = 0; i < CH; i++) begin
            if (!r_req[i] && ($urandom_range(0, 1) == 1)) begin
               r_req[i]  = 1'b1;
               r_we[i]   = ($urandom_range(0, 2) == 0);
               r_addr[i] = AW'($urandom_range(0, 31));
               r_data[i] = DW'($urandom);
               r_be[i]   = BW'($urandom_range(0, 15));
            end
         end
         step(1'b0);
         if (last_grant >= 0) r_req[last_grant] = 1'b0;
      end
      clr_reqs();
      repeat (3) step(1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
